// File: rtl/proc_run_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_pkg
// Description : Shared state encodings and signature helper for the
//               processor run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_run_pkg;

   // Run-controller state encodings
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RST_HOLD = 2'd1;
   localparam logic [1:0] RUN      = 2'd2;
   localparam logic [1:0] DONE     = 2'd3;

   // Widest signature the rotate helper handles
   localparam int SIG_MAX_W = 64;

   // Rotate the low w bits of v left by one; bits above w come back as zero
   function automatic logic [SIG_MAX_W-1:0] sig_rotl1(input logic [SIG_MAX_W-1:0] v,
                                                      input int w);
      logic [SIG_MAX_W-1:0] mask;
      mask = (w >= SIG_MAX_W) ? {SIG_MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
      return ((v << 1) | (v >> (w - 1))) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/proc_run_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_controller_if
// Description : Control, writeback and trace-read signals between the run
//               controller and its surroundings (core + host/bench).
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_run_controller_if #(
   parameter int XLEN = 32,
   parameter int AW   = 4
) ();
   logic            start;
   logic            stop_on_zero;
   logic            wb_valid;
   logic [XLEN-1:0] wb_data;
   logic            zero_flag;
   logic [AW-1:0]   rd_addr;
   logic            core_reset;
   logic            running;
   logic            done;
   logic            timeout;
   logic [31:0]     cycle_count;
   logic [AW:0]     trace_count;
   logic            trace_overflow;
   logic [XLEN-1:0] signature;
   logic [XLEN-1:0] rd_data;

   // Host / core side
   modport master (
      output start, stop_on_zero, wb_valid, wb_data, zero_flag, rd_addr,
      input  core_reset, running, done, timeout, cycle_count, trace_count,
             trace_overflow, signature, rd_data
   );

   // Controller side
   modport slave (
      input  start, stop_on_zero, wb_valid, wb_data, zero_flag, rd_addr,
      output core_reset, running, done, timeout, cycle_count, trace_count,
             trace_overflow, signature, rd_data
   );
endinterface
`default_nettype wire

// File: rtl/proc_run_controller_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : trace_buf
// Description : TRACE_DEPTH x XLEN writeback trace storage, one synchronous
//               write port and one asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_buf #(
   parameter  int XLEN        = 32,
   parameter  int TRACE_DEPTH = 16,
   localparam int AW          = $clog2(TRACE_DEPTH)
) (
   input  wire logic            clk,
   input  wire logic            we,
   input  wire logic [AW-1:0]   waddr,
   input  wire logic [XLEN-1:0] wdata,
   input  wire logic [AW-1:0]   raddr,
   output logic      [XLEN-1:0] rdata
);
   logic [XLEN-1:0] mem [TRACE_DEPTH];

   // Store one captured writeback per enabled edge; contents need no reset
   // because the controller masks reads beyond the valid entry count.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule
`default_nettype wire

// File: rtl/proc_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_controller
// Description : Sequences core reset, bounds execution by a cycle budget and
//               optional halt-on-zero, and captures the writeback stream into
//               a trace buffer plus a rolling rotate-xor signature.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_run_controller
   import proc_run_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int RST_CYCLES  = 1,
   parameter int MAX_CYCLES  = 12,
   parameter int TRACE_DEPTH = 16,
   parameter int AW          = $clog2(TRACE_DEPTH)
) (
   input wire logic             clk,
   input wire logic             reset,
   proc_run_controller_if.slave bus
);
   localparam int          HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [31:0] MAX_C     = 32'(MAX_CYCLES);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(TRACE_DEPTH);

   logic [1:0]        state;
   logic [HOLD_W-1:0] hold_left;
   logic              core_rst;
   logic              run_q;
   logic              done_q;
   logic              tmo;
   logic              ovf;
   logic              stop_lat;
   logic [31:0]       cyc;
   logic [AW:0]       tcnt;
   logic [XLEN-1:0]   sig;

   logic [31:0]       cyc_next;
   logic [XLEN-1:0]   sig_next;
   logic              full;
   logic              trace_we;
   logic [XLEN-1:0]   buf_rdata;

   assign cyc_next = cyc + 32'd1;
   assign sig_next = XLEN'(sig_rotl1(SIG_MAX_W'(sig), XLEN)) ^ bus.wb_data;
   assign full     = (tcnt == DEPTH_CNT);
   // Reset takes priority over a capture on the same edge
   assign trace_we = !reset && (state == RUN) && bus.wb_valid && !full;

   // FSM, run counters, signature and result flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         hold_left <= '0;
         core_rst  <= 1'b1;
         run_q     <= 1'b0;
         done_q    <= 1'b0;
         tmo       <= 1'b0;
         ovf       <= 1'b0;
         stop_lat  <= 1'b0;
         cyc       <= '0;
         tcnt      <= '0;
         sig       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state     <= RST_HOLD;
                  hold_left <= HOLD_W'(RST_CYCLES - 1);
                  core_rst  <= 1'b1;
                  run_q     <= 1'b0;
                  done_q    <= 1'b0;
                  tmo       <= 1'b0;
                  ovf       <= 1'b0;
                  stop_lat  <= bus.stop_on_zero;
                  cyc       <= '0;
                  tcnt      <= '0;
                  sig       <= '0;
               end
            end
            RST_HOLD: begin
               if (hold_left == '0) begin
                  state    <= RUN;
                  core_rst <= 1'b0;
                  run_q    <= 1'b1;
               end else begin
                  hold_left <= hold_left - 1'b1;
               end
            end
            RUN: begin
               cyc <= cyc_next;
               if (bus.wb_valid) begin
                  sig <= sig_next;
                  if (!full) tcnt <= tcnt + 1'b1;
                  else       ovf  <= 1'b1;
               end
               // Halt has priority over budget exhaustion on the same edge
               if (stop_lat && bus.zero_flag) begin
                  state    <= DONE;
                  core_rst <= 1'b1;
                  run_q    <= 1'b0;
                  done_q   <= 1'b1;
                  tmo      <= 1'b0;
               end else if (cyc_next == MAX_C) begin
                  state    <= DONE;
                  core_rst <= 1'b1;
                  run_q    <= 1'b0;
                  done_q   <= 1'b1;
                  tmo      <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   trace_buf #(
      .XLEN        (XLEN),
      .TRACE_DEPTH (TRACE_DEPTH)
   ) u_trace_buf (
      .clk   (clk),
      .we    (trace_we),
      .waddr (tcnt[AW-1:0]),
      .wdata (bus.wb_data),
      .raddr (bus.rd_addr),
      .rdata (buf_rdata)
   );

   assign bus.core_reset     = core_rst;
   assign bus.running        = run_q;
   assign bus.done           = done_q;
   assign bus.timeout        = tmo;
   assign bus.cycle_count    = cyc;
   assign bus.trace_count    = tcnt;
   assign bus.trace_overflow = ovf;
   assign bus.signature      = sig;
   assign bus.rd_data        = ({1'b0, bus.rd_addr} < tcnt) ? buf_rdata : '0;
endmodule
`default_nettype wire
